// File: rtl/bp_profiler_pkg.sv
// bp_profiler_pkg
//   Shared constants for the stall-attribution profiler.
//   The bucket address map is shared by the read port (rd_addr_i) and by the
//   sticky overflow vector (overflow_o), so both index buckets the same way:
//     0      total cycles
//     1      committed instructions
//     2      cycles with no commit and no stall reason
//     3 + k  cycles attributed to stall reason k
package bp_profiler_pkg;

    localparam int e_prof_addr_cycle       = 0;
    localparam int e_prof_addr_instret     = 1;
    localparam int e_prof_addr_unattr      = 2;
    localparam int e_prof_addr_reason_base = 3;

    localparam int snap_cnt_width_gp = 16;

    // Number of buckets for a given number of stall reasons.
    function automatic int num_buckets(input int num_reasons);
        return num_reasons + e_prof_addr_reason_base;
    endfunction

endpackage

// File: rtl/bp_profiler_counter.sv
// bp_profiler_counter
//   One profiling counter with increment, synchronous clear, saturate-or-wrap
//   overflow handling and a sticky overflow flag.
//   next_o / overflow_next_o are the values the registers take at the next
//   edge when no clear is applied; the parent samples them for snapshots so a
//   snapshot includes this cycle's increment even when a clear discards it.
// Ports:
//   clk_i           clock
//   reset_n_i       synchronous active-low reset
//   inc_i           count this cycle
//   clear_i         zero the counter and its overflow flag
//   next_o          incremented (pre-clear) counter value
//   overflow_next_o incremented (pre-clear) sticky overflow flag
module bp_profiler_counter #(
    parameter int ctr_width_p = 32,
    parameter bit saturate_p  = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   inc_i,
    input  logic                   clear_i,
    output logic [ctr_width_p-1:0] next_o,
    output logic                   overflow_next_o
);

    logic [ctr_width_p-1:0] count_q;
    logic                   overflow_q;
    logic                   at_max;

    assign at_max = &count_q;

    always_comb begin
        next_o = count_q;
        if (inc_i) begin
            if (!at_max) begin
                next_o = count_q + ctr_width_p'(1);
            end else if (!saturate_p) begin
                next_o = '0;
            end
        end
    end

    assign overflow_next_o = overflow_q | (inc_i & at_max);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i || clear_i) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= next_o;
            overflow_q <= overflow_next_o;
        end
    end

endmodule

// File: rtl/bp_nonsynth_stall_histogram.sv
// bp_nonsynth_stall_histogram
//   Per-core stall-attribution counter bank. Every active cycle is counted in
//   "cycles" and in exactly one of: instret, a stall reason (lowest set index
//   wins), or unattributed. Live counters are copied atomically into a
//   snapshot bank on request or on window rollover; software reads only the
//   snapshot bank.
// Ports:
//   clk_i, reset_n_i    clock, synchronous active-low reset
//   freeze_i            core freeze; counting stops while its delayed copy is 1
//   instret_i           instruction committed this cycle
//   stall_reason_i      multi-hot stall-reason vector
//   clear_i             zero live counters, live overflow bits, window counter
//   snapshot_i          manual snapshot request
//   window_i            auto-snapshot period in active cycles, 0 = off
//   rd_v_i, rd_addr_i   read request and bucket address
//   rd_v_o, rd_data_o   read response (one cycle after the request)
//   snap_cnt_o          snapshot sequence number (wraps)
//   overflow_o          sticky overflow bits captured with the snapshot
module bp_nonsynth_stall_histogram
    import bp_profiler_pkg::*;
#(
    parameter  int num_reasons_p  = 32,
    parameter  int ctr_width_p    = 32,
    parameter  int freeze_delay_p = 8,
    parameter  int saturate_p     = 1,
    parameter  int window_width_p = 32,
    localparam int num_buckets_lp = num_buckets(num_reasons_p),
    localparam int addr_width_lp  = $clog2(num_buckets_lp)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         freeze_i,
    input  logic                         instret_i,
    input  logic [num_reasons_p-1:0]     stall_reason_i,
    input  logic                         clear_i,
    input  logic                         snapshot_i,
    input  logic [window_width_p-1:0]    window_i,
    input  logic                         rd_v_i,
    input  logic [addr_width_lp-1:0]     rd_addr_i,
    output logic                         rd_v_o,
    output logic [ctr_width_p-1:0]       rd_data_o,
    output logic [snap_cnt_width_gp-1:0] snap_cnt_o,
    output logic [num_buckets_lp-1:0]    overflow_o
);

    // Freeze delay chain. Reset loads ones so the first freeze_delay_p cycles
    // after reset are never counted, matching a pipeline that is still filling.
    logic [freeze_delay_p-1:0] freeze_q;
    logic                      active;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            freeze_q <= '1;
        end else begin
            freeze_q[0] <= freeze_i;
            for (int i = 1; i < freeze_delay_p; i++) begin
                freeze_q[i] <= freeze_q[i-1];
            end
        end
    end

    assign active = reset_n_i & ~freeze_q[freeze_delay_p-1];

    // Priority encoder, lowest index first, producing a one-hot pick.
    logic [num_reasons_p-1:0] reason_oh;
    logic                     reason_any;

    always_comb begin
        reason_oh  = '0;
        reason_any = 1'b0;
        for (int k = 0; k < num_reasons_p; k++) begin
            if (stall_reason_i[k] && !reason_any) begin
                reason_oh[k] = 1'b1;
                reason_any   = 1'b1;
            end
        end
    end

    // Bucket increment vector; a commit overrides any stall reason.
    logic [num_buckets_lp-1:0] inc;

    always_comb begin
        inc                      = '0;
        inc[e_prof_addr_cycle]   = active;
        inc[e_prof_addr_instret] = active & instret_i;
        inc[e_prof_addr_unattr]  = active & ~instret_i & ~reason_any;
        if (active && !instret_i) begin
            inc[num_buckets_lp-1:e_prof_addr_reason_base] = reason_oh;
        end
    end

    // Window counter. The >= compare makes a shrinking window_i roll over on
    // the next active cycle instead of running all the way around.
    logic [window_width_p-1:0] win_q;
    logic                      window_en;
    logic                      rollover;
    logic                      take_snap;
    logic                      live_clear;

    assign window_en  = (window_i != '0);
    assign rollover   = active & window_en & (win_q >= (window_i - window_width_p'(1)));
    // Inactive (frozen) cycles leave all live and snapshot state untouched,
    // so clear and snapshot requests only act in active cycles.
    assign take_snap  = active & (snapshot_i | rollover);
    assign live_clear = active & (clear_i | rollover);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            win_q <= '0;
        end else if (live_clear) begin
            win_q <= '0;
        end else if (active && window_en) begin
            win_q <= win_q + window_width_p'(1);
        end
    end

    // Live counter bank.
    logic [ctr_width_p-1:0]    ctr_next [num_buckets_lp];
    logic [num_buckets_lp-1:0] ovf_next;

    for (genvar b = 0; b < num_buckets_lp; b++) begin : g_ctr
        bp_profiler_counter #(
            .ctr_width_p(ctr_width_p),
            .saturate_p (saturate_p != 0)
        ) u_ctr (
            .clk_i          (clk_i),
            .reset_n_i      (reset_n_i),
            .inc_i          (inc[b]),
            .clear_i        (live_clear),
            .next_o         (ctr_next[b]),
            .overflow_next_o(ovf_next[b])
        );
    end

    // Snapshot bank captures the incremented, pre-clear live values.
    logic [ctr_width_p-1:0] snap_q [num_buckets_lp];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int b = 0; b < num_buckets_lp; b++) begin
                snap_q[b] <= '0;
            end
            overflow_o <= '0;
            snap_cnt_o <= '0;
        end else if (take_snap) begin
            for (int b = 0; b < num_buckets_lp; b++) begin
                snap_q[b] <= ctr_next[b];
            end
            overflow_o <= ovf_next;
            snap_cnt_o <= snap_cnt_o + snap_cnt_width_gp'(1);
        end
    end

    // Read port: a request (rd_v_i) is always accepted, there is no ready.
    // The response appears on the next edge with rd_v_o high for exactly one
    // cycle; it reads the snapshot bank before any same-cycle snapshot lands.
    // Addresses past the last bucket return 0; rd_data_o holds between reads.
    logic [ctr_width_p-1:0] rd_sel;

    always_comb begin
        rd_sel = '0;
        for (int b = 0; b < num_buckets_lp; b++) begin
            if (rd_addr_i == addr_width_lp'(b)) begin
                rd_sel = snap_q[b];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rd_v_o    <= 1'b0;
            rd_data_o <= '0;
        end else begin
            rd_v_o <= rd_v_i;
            if (rd_v_i) begin
                rd_data_o <= rd_sel;
            end
        end
    end

endmodule

// File: doc/bp_nonsynth_stall_histogram.md
Name: bp_nonsynth_stall_histogram

Overview:
Synthesizable per-core stall-attribution counter bank; successor to the simulation-only stall trace, so stall histograms can be collected on FPGA.
- Consumes the final-stage stall-reason vector and commit strobe each cycle.
- Attributes every counted cycle to exactly one bucket.
- Exposes atomic snapshots to the PS through a registered read port.
- Adds parametrised reason count, counter width, saturate/wrap mode, and windowed auto-snapshot.

Parameters:
num_reasons_p, 32, number of stall-reason buckets (width of the reason vector)
ctr_width_p, 32, width of every counter and of rd_data_o
freeze_delay_p, 8, cycles that freeze_i is delayed to align with the stall pipeline; must be ≥1
saturate_p, 1, 1 = counters stick at all-ones on overflow; 0 = counters wrap to 0
window_width_p, 32, width of window_i and of the window counter

Ports:
clk_i  in  1  clock; single clock domain
reset_n_i  in  1  reset; synchronous, active-low
freeze_i  in  1  core freeze; counting is suppressed while the delayed copy is high
instret_i  in  1  an instruction committed this cycle
stall_reason_i  in  num_reasons_p  multi-hot reason vector; the lowest set index wins
clear_i  in  1  zero the live counters
snapshot_i  in  1  manual snapshot request
window_i  in  window_width_p  auto-snapshot period in active cycles; 0 disables it
rd_v_i  in  1  read request
rd_addr_i  in  clog2(num_reasons_p+3)  bucket select; 0 = cycles, 1 = instret, 2 = unattributed, 3+k = reason k
rd_v_o  out  1  read data valid
rd_data_o  out  ctr_width_p  snapshot value of the selected bucket
snap_cnt_o  out  16  snapshot sequence number; wraps; used by software to detect torn reads
overflow_o  out  num_reasons_p+3  sticky overflow bits of the snapshot, indexed like rd_addr_i

Behaviour:
- Reset (reset_n_i=0 at posedge): all live counters, snapshots, live and snapshot overflow bits, window counter, snap_cnt_o, rd_v_o and rd_data_o become 0.
- Reset also forces every freeze-delay stage to 1, so nothing is counted for freeze_delay_p cycles after reset deasserts.
- Reset asserted mid-operation clears everything in one cycle; a pending read is dropped.
- Active cycle: reset_n_i=1 and the delayed freeze is 0.
- In each active cycle:
  - cycles increments.
  - If instret_i, instret increments (stall_reason_i is ignored).
  - Else if stall_reason_i is nonzero, reason[lowest set index] increments.
  - Else unattributed increments.
- Invariant while no overflow occurs: cycles = instret + unattributed + Σreason.
- Inactive cycles change nothing except the read path.
- Overflow on increment at all-ones:
  - saturate_p=1: the counter holds at all-ones.
  - saturate_p=0: the counter wraps to 0.
  - Either way, that counter's live overflow bit is set and stays set until the live counters are cleared.
- Window logic:
  - When window_i≠0, the window counter counts active cycles.
  - On the active cycle where it equals window_i-1, a rollover fires: auto-snapshot, then the live counters, live overflow bits and window counter go to 0.
  - A change to window_i takes effect on the next comparison; if the window counter already exceeds window_i-1, a rollover fires on the next active cycle.
- Snapshot (snapshot_i or rollover):
  - All snapshot registers capture the live next-values, including this cycle's increment.
  - overflow_o captures the live overflow next-values.
  - snap_cnt_o increments by 1 (wraps 0xFFFF→0).
  - snapshot_i and a rollover in the same cycle produce a single snapshot (+1).
- clear_i:
  - Live counters, live overflow bits and window counter become 0; this cycle's increment is discarded from the live state.
  - If a snapshot occurs in the same cycle, the snapshot still captures the incremented pre-clear values.
- Read path:
  - On rd_v_i, rd_data_o is registered from the snapshot bank at the next posedge, and rd_v_o=1 for that one cycle.
  - Latency is 1; there is no backpressure; back-to-back reads are allowed every cycle.
  - A read issued in the same cycle as a snapshot returns the pre-snapshot value.
  - An out-of-range rd_addr_i returns 0.
  - rd_data_o holds its last value when rd_v_o=0.
- Snapshots are never modified by clear_i.

Decomposition:
- bp_profiler_pkg: localparams e_prof_addr_cycle=0, e_prof_addr_instret=1, e_prof_addr_unattr=2, e_prof_addr_reason_base=3.
- Sub-module bp_profiler_counter: one ctr_width_p counter with inc/clear, saturate/wrap, and a sticky overflow output. Instantiated num_reasons_p+3 times.
- Freeze delay is a reset-to-1 shift chain of freeze_delay_p stages. The lowest-set-bit pick is a priority encoder (lo_to_hi).

Test Plan:
- Reset, release, freeze_i=0, 20 cycles with instret_i=1 → snapshot at cycle 20 gives cycles=12, instret=12 (first 8 cycles masked by the freeze chain).
- 10 active cycles with stall_reason_i=0b0110, instret_i=0, then snapshot_i → reason1=10, reason2=0, cycles=10.
- window_i=5 with 12 active unattributed cycles → two rollovers, snap_cnt_o=2, snapshot unattributed=5, live value 2 afterwards.
- ctr_width_p=4, saturate_p=1, 20 active cycles → snapshot cycles=15, overflow_o[0]=1. With saturate_p=0 → cycles=4, overflow_o[0]=1.
- clear_i and snapshot_i in the same cycle after 7 active cycles → snapshot cycles=8, live cycles=0 next cycle; a read of address 0 issued in that same cycle returns the old snapshot.
- rd_v_i with rd_addr_i=num_reasons_p+3 → rd_v_o=1 next cycle, rd_data_o=0. Assert reset_n_i=0 mid-window → all outputs 0 next cycle.
